// File: rtl/lsu_split_align_pkg.sv
// Shared definitions for the load/store split/align unit: funct3 encodings,
// FSM state enum and the access-size decode helper.
package lsu_pkg;

  // RISC-V load/store funct3 encodings
  localparam logic [2:0] BYTE   = 3'b000;
  localparam logic [2:0] HALF   = 3'b001;
  localparam logic [2:0] WORD   = 3'b010;
  localparam logic [2:0] DWORD  = 3'b011;
  localparam logic [2:0] BYTE_U = 3'b100;
  localparam logic [2:0] HALF_U = 3'b101;
  localparam logic [2:0] WORD_U = 3'b110;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_BEAT0 = 3'd1,
    S_WAIT0 = 3'd2,
    S_BEAT1 = 3'd3,
    S_WAIT1 = 3'd4,
    S_RESP  = 3'd5
  } lsu_state_e;

  // Access size in bytes (1, 2, 4 or 8) from the low two funct3 bits
  function automatic logic [3:0] size_from_funct3(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 4'd1;
      2'b01:   return 4'd2;
      2'b10:   return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/lsu_split_align_lane_steer.sv
// Combinational lane steering shared by the store and load paths:
// stores are byte-masked and shifted into a two-word window, loads are
// extracted from a two-word window and sign/zero-extended.
module lsu_lane_steer #(
  parameter int XLEN = 32
) (
  input  logic [$clog2(XLEN/8)-1:0] i_off,
  input  logic [3:0]                i_size,
  input  logic                      i_unsigned,
  input  logic [XLEN-1:0]           i_wdata,
  input  logic [XLEN-1:0]           i_rdata_lo,
  input  logic [XLEN-1:0]           i_rdata_hi,
  output logic [2*XLEN-1:0]         o_wdata_wide,
  output logic [2*XLEN/8-1:0]       o_be_wide,
  output logic [XLEN-1:0]           o_load
);

  localparam int NB = XLEN / 8;

  logic [NB-1:0]   w_mask;
  logic [XLEN-1:0] w_wdata_m;
  logic [XLEN-1:0] w_raw;
  logic            w_sign;
  logic            w_fill;

  // Load window shifted down so the addressed byte lands in lane 0
  assign w_raw = XLEN'({i_rdata_hi, i_rdata_lo} >> {i_off, 3'b000});

  // Store window: masked data and byte enables shifted up to the access offset
  assign o_wdata_wide = {{XLEN{1'b0}}, w_wdata_m} << {i_off, 3'b000};
  assign o_be_wide    = {{NB{1'b0}}, w_mask} << i_off;

  // Size mask, store data masking, and load truncate/extend
  always_comb begin
    // NOTE: every variable gets a default first so no path can leave it unassigned and infer a latch.
    w_mask    = '0;
    w_wdata_m = '0;
    w_sign    = 1'b0;
    o_load    = '0;
    for (int b = 0; b < NB; b++) begin
      if (b < int'(i_size)) begin
        w_mask[b]          = 1'b1;
        w_wdata_m[8*b +: 8] = i_wdata[8*b +: 8];
      end
    end
    case (i_size)
      4'd1:    w_sign = w_raw[7];
      4'd2:    w_sign = w_raw[15];
      4'd4:    w_sign = w_raw[31];
      default: w_sign = w_raw[XLEN-1];
    endcase
    w_fill = ~i_unsigned & w_sign;
    for (int b = 0; b < NB; b++) begin
      o_load[8*b +: 8] = (b < int'(i_size)) ? w_raw[8*b +: 8] : {8{w_fill}};
    end
  end

endmodule

// File: rtl/lsu_split_align.sv
// Load/store unit front end: accepts one core access, issues one or two
// word-aligned memory beats (two when the access crosses a word boundary),
// merges/extends load data and returns a single response.
// Build option: define LSU_MISALIGN_TRAP_EN to reject word-crossing
// accesses with rsp_err instead of splitting them.
module lsu_split_align
  import lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_funct3,
  input  logic              req_we,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [XLEN/8-1:0] mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);

  lsu_state_e        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_funct3;
  logic              r_we;
  logic [XLEN-1:0]   r_wdata;
  logic [XLEN-1:0]   r_rdata0;
  logic              r_req_ready;
  logic              r_mem_valid;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_we;
  logic [NB-1:0]     r_mem_be;
  logic [XLEN-1:0]   r_mem_wdata;
  logic              r_rsp_valid;
  logic [XLEN-1:0]   r_rsp_rdata;
  logic              r_rsp_err;

  logic              w_idle;
  logic [ADDR_W-1:0] w_addr;
  logic [2:0]        w_funct3;
  logic              w_we;
  logic [XLEN-1:0]   w_wdata;
  logic [OFF_W-1:0]  w_off;
  logic [3:0]        w_size;
  logic              w_split;
  logic              w_illegal;
  logic              w_err;
  logic [ADDR_W-1:0] w_word;
  logic [XLEN-1:0]   w_rdata_lo;
  logic [XLEN-1:0]   w_rdata_hi;
  logic [2*XLEN-1:0] w_wdata_wide;
  logic [2*NB-1:0]   w_be_wide;
  logic [XLEN-1:0]   w_load;
  logic [XLEN-1:0]   w_load_rsp;

  // In IDLE the incoming request drives decode so the first beat can be
  // registered on the acceptance edge; afterwards the latched copy does.
  assign w_idle   = (r_state == S_IDLE);
  assign w_addr   = w_idle ? req_addr   : r_addr;
  assign w_funct3 = w_idle ? req_funct3 : r_funct3;
  assign w_we     = w_idle ? req_we     : r_we;
  assign w_wdata  = w_idle ? req_wdata  : r_wdata;

  assign w_off   = w_addr[OFF_W-1:0];
  assign w_size  = size_from_funct3(w_funct3);
  assign w_split = (int'(w_off) + int'(w_size)) > NB;
  assign w_word  = {w_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  assign w_illegal = (w_funct3 == 3'b111)
                   || ((XLEN == 32) && ((w_funct3 == DWORD) || (w_funct3 == WORD_U)))
                   || (w_we && w_funct3[2]);

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_err      = w_illegal || w_split;
  assign w_rdata_hi = '0;
`else
  logic [ADDR_W-1:0] w_word_next;
  assign w_err       = w_illegal;
  assign w_word_next = w_word + ADDR_W'(NB);
  assign w_rdata_hi  = (r_state == S_WAIT1) ? mem_rdata : '0;
`endif

  // The beat completing this cycle is merged straight from the memory bus
  assign w_rdata_lo = (r_state == S_WAIT0) ? mem_rdata : r_rdata0;
  assign w_load_rsp = w_we ? '0 : w_load;

  lsu_lane_steer #(.XLEN(XLEN)) u_steer (
    .i_off        (w_off),
    .i_size       (w_size),
    .i_unsigned   (w_funct3[2]),
    .i_wdata      (w_wdata),
    .i_rdata_lo   (w_rdata_lo),
    .i_rdata_hi   (w_rdata_hi),
    .o_wdata_wide (w_wdata_wide),
    .o_be_wide    (w_be_wide),
    .o_load       (w_load)
  );

  // Access sequencing FSM with registered handshake and data outputs
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_funct3    <= '0;
      r_we        <= 1'b0;
      r_wdata     <= '0;
      r_rdata0    <= '0;
      r_req_ready <= 1'b1;
      r_mem_valid <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= '0;
      r_mem_wdata <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_addr      <= req_addr;
            r_funct3    <= req_funct3;
            r_we        <= req_we;
            r_wdata     <= req_wdata;
            r_req_ready <= 1'b0;
            if (w_err) begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_rdata <= '0;
              r_rsp_err   <= 1'b1;
            end else begin
              r_state     <= S_BEAT0;
              r_mem_valid <= 1'b1;
              r_mem_addr  <= w_word;
              r_mem_we    <= w_we;
              r_mem_be    <= w_be_wide[NB-1:0];
              r_mem_wdata <= w_wdata_wide[XLEN-1:0];
            end
          end
        end
        S_BEAT0: begin
          if (mem_ready) begin
            r_mem_valid <= 1'b0;
            r_state     <= S_WAIT0;
          end
        end
        S_WAIT0: begin
          if (mem_rvalid) begin
            r_rdata0 <= mem_rdata;
`ifndef LSU_MISALIGN_TRAP_EN
            if (w_split) begin
              r_state     <= S_BEAT1;
              r_mem_valid <= 1'b1;
              r_mem_addr  <= w_word_next;
              r_mem_be    <= w_be_wide[2*NB-1:NB];
              r_mem_wdata <= w_wdata_wide[2*XLEN-1:XLEN];
            end else
`endif
            begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_rdata <= w_load_rsp;
              r_rsp_err   <= 1'b0;
            end
          end
        end
`ifndef LSU_MISALIGN_TRAP_EN
        S_BEAT1: begin
          if (mem_ready) begin
            r_mem_valid <= 1'b0;
            r_state     <= S_WAIT1;
          end
        end
        S_WAIT1: begin
          if (mem_rvalid) begin
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= w_load_rsp;
            r_rsp_err   <= 1'b0;
          end
        end
`endif
        S_RESP: begin
          if (rsp_ready) begin
            r_state     <= S_IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_req_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_mem_valid <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign mem_valid = r_mem_valid;
  assign mem_addr  = r_mem_addr;
  assign mem_we    = r_mem_we;
  assign mem_be    = r_mem_be;
  assign mem_wdata = r_mem_wdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule
